// File: rtl/comp_serial.sv
// rtl/comp_serial.sv - serial unsigned magnitude comparator, one 2-bit digit per cycle, MSB first
module comp_serial #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic             EQ,
   output logic             GT,
   output logic             LT
);

   localparam int ND = WIDTH / 2;
   localparam int IW = (ND > 1) ? $clog2(ND) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] a_r, b_r;
   logic [IW-1:0]    idx;
   logic             eq_r, gt_r;
   logic [1:0]       a_dig, b_dig;
   logic             eq_nx, gt_nx;

   // Select digit pair idx by shifting it down to the bottom two bits
   always_comb begin
      a_dig = 2'(a_r >> {idx, 1'b0});
      b_dig = 2'(b_r >> {idx, 1'b0});
      eq_nx = eq_r;
      gt_nx = gt_r;
      if (a_dig != b_dig) begin
         eq_nx = 1'b0;
         gt_nx = (a_dig > b_dig);
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if ((a_dig != b_dig) || (idx == '0)) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         eq_r <= 1'b0;
         gt_r <= 1'b0;
         EQ   <= 1'b0;
         GT   <= 1'b0;
         LT   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_r  <= A;
                  b_r  <= B;
                  idx  <= IW'(ND - 1);
                  eq_r <= 1'b1;
                  gt_r <= 1'b0;
                  EQ   <= 1'b0;
                  GT   <= 1'b0;
                  LT   <= 1'b0;
               end
            end
            RUN: begin
               eq_r <= eq_nx;
               gt_r <= gt_nx;
               // Results are captured on the edge that enters DONE and held until the next start
               if (state_nx == DONE) begin
                  EQ <= eq_nx;
                  GT <= gt_nx;
                  LT <= ~eq_nx & ~gt_nx;
               end else begin
                  idx <= idx - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: tb/tb_comp_serial.sv
// tb/tb_comp_serial.sv - self-checking bench for comp_serial at WIDTH=16 and WIDTH=2
module tb_comp_serial;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start16 = 1'b0, start2 = 1'b0;
   logic [15:0] a16 = '0, b16 = '0;
   logic [1:0]  a2 = '0, b2 = '0;
   logic        busy16, done16, EQ16, GT16, LT16;
   logic        busy2, done2, EQ2, GT2, LT2;

   int total = 0;
   int bad = 0;
   bit armed = 0;

   // Timeline model: ph = cycles since the accepting edge (0 = idle), n = digits examined
   int ph[2] = '{0, 0};
   int n[2]  = '{1, 1};
   bit pe[2], pg[2], pl[2];
   bit xe[2] = '{0, 0}, xg[2] = '{0, 0}, xl[2] = '{0, 0};

   always #5 clk = ~clk;

   comp_serial #(.WIDTH(16)) dut16 (
      .clk(clk), .reset(reset), .start(start16), .A(a16), .B(b16),
      .busy(busy16), .done(done16), .EQ(EQ16), .GT(GT16), .LT(LT16)
   );

   comp_serial #(.WIDTH(2)) dut2 (
      .clk(clk), .reset(reset), .start(start2), .A(a2), .B(b2),
      .busy(busy2), .done(done2), .EQ(EQ2), .GT(GT2), .LT(LT2)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Digits examined = position of the highest differing 2-bit digit, counted from the top
   function automatic int ndig(input logic [15:0] a, input logic [15:0] b, input int w);
      logic [15:0] x;
      int p;
      x = a ^ b;
      if (x == 0) return w / 2;
      p = 0;
      for (int i = 0; i < w; i++) if (x[i]) p = i;
      return w / 2 - p / 2;
   endfunction

   task automatic mstep(input int k, input int w, input logic rst, input logic s,
                        input logic [15:0] a, input logic [15:0] b);
      if (rst) begin
         ph[k] = 0;
         xe[k] = 0; xg[k] = 0; xl[k] = 0;
      end else if (ph[k] == 0) begin
         if (s) begin
            ph[k] = 1;
            n[k]  = ndig(a, b, w);
            pe[k] = (a == b); pg[k] = (a > b); pl[k] = (a < b);
            xe[k] = 0; xg[k] = 0; xl[k] = 0;
         end
      end else if (ph[k] == n[k] + 1) begin
         ph[k] = 0;
      end else begin
         ph[k]++;
         if (ph[k] == n[k] + 1) begin
            xe[k] = pe[k]; xg[k] = pg[k]; xl[k] = pl[k];
         end
      end
   endtask

   always @(posedge clk) begin
      if (reset) armed = 1;
      mstep(0, 16, reset, start16, a16, b16);
      mstep(1, 2, reset, start2, {14'b0, a2}, {14'b0, b2});
   end

   always @(negedge clk) begin
      if (armed) begin
         chk("busy16", busy16, (ph[0] >= 1 && ph[0] <= n[0]));
         chk("done16", done16, (ph[0] == n[0] + 1));
         chk("res16", {EQ16, GT16, LT16}, {xe[0], xg[0], xl[0]});
         chk("busy2", busy2, (ph[1] >= 1 && ph[1] <= n[1]));
         chk("done2", done2, (ph[1] == n[1] + 1));
         chk("res2", {EQ2, GT2, LT2}, {xe[1], xg[1], xl[1]});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run16(input logic [15:0] a, input logic [15:0] b, input int exp_lat,
                        input logic [2:0] exp_res, input string nm, input bit scramble, input bit poke);
      int lat;
      bit got;
      a16 = a; b16 = b; start16 = 1'b1;
      step();
      start16 = poke;
      lat = 0; got = 0;
      while (!got && lat < 20) begin
         lat++;
         @(negedge clk);
         if (done16) got = 1;
         else begin
            step();
            if (scramble) begin
               a16 = 16'($urandom); b16 = 16'($urandom);
            end
         end
      end
      start16 = 1'b0;
      chk({nm, "_lat"}, lat, exp_lat);
      chk({nm, "_res"}, {EQ16, GT16, LT16}, exp_res);
      step();
   endtask

   task automatic run2(input logic [1:0] a, input logic [1:0] b, input logic [2:0] exp_res, input string nm);
      int lat;
      a2 = a; b2 = b; start2 = 1'b1;
      step();
      start2 = 1'b0;
      lat = 1;
      @(negedge clk);
      while (!done2 && lat < 10) begin
         step();
         lat++;
         @(negedge clk);
      end
      chk({nm, "_lat"}, lat, 2);
      chk({nm, "_res"}, {EQ2, GT2, LT2}, exp_res);
      step();
   endtask

   initial begin
      int cnt_done, cnt_busy;
      repeat (2) step();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_out", {busy16, done16, EQ16, GT16, LT16}, 5'b0);
      chk("nd_eq", ndig(16'h1234, 16'h1234, 16), 8);
      chk("nd_top", ndig(16'hC000, 16'h4000, 16), 1);
      chk("nd_low", ndig(16'h0001, 16'h0002, 16), 8);
      step();

      run16(16'h1234, 16'h1234, 9, 3'b100, "eq", 0, 0);
      run16(16'hC000, 16'h4000, 2, 3'b010, "gt_top", 0, 0);
      run16(16'h0001, 16'h0002, 9, 3'b001, "lt_low_scr", 1, 0);
      run16(16'h00F0, 16'h00E0, 7, 3'b010, "gt_mid_poke", 0, 1);
      repeat (3) step();
      @(negedge clk);
      chk("hold", {EQ16, GT16, LT16}, 3'b010);

      // Held start: n=1 comparisons repeat every three cycles
      a16 = 16'hC000; b16 = 16'h4000; start16 = 1'b1;
      cnt_done = 0; cnt_busy = 0;
      for (int i = 0; i < 9; i++) begin
         step();
         @(negedge clk);
         cnt_done += int'(done16);
         cnt_busy += int'(busy16);
      end
      start16 = 1'b0;
      chk("held_done", cnt_done, 3);
      chk("held_busy", cnt_busy, 3);
      step();

      // Reset in the 4th RUN cycle
      a16 = 16'h1234; b16 = 16'h1234; start16 = 1'b1;
      step();
      start16 = 1'b0;
      repeat (3) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clk);
      chk("abort_out", {busy16, done16, EQ16, GT16, LT16}, 5'b0);
      cnt_done = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         @(negedge clk);
         cnt_done += int'(done16);
      end
      chk("abort_nodone", cnt_done, 0);
      step();
      run16(16'h4000, 16'hC000, 2, 3'b001, "after_rst", 0, 0);

      reset = 1'b1; start16 = 1'b1;
      step();
      reset = 1'b0; start16 = 1'b0;
      @(negedge clk);
      chk("rst_prio", busy16, 1'b0);
      step();

      run2(2'd3, 2'd1, 3'b010, "w2_gt");
      run2(2'd2, 2'd2, 3'b100, "w2_eq");
      run2(2'd0, 2'd3, 3'b001, "w2_lt");

      fork
         begin
            for (int i = 0; i < 10000; i++) begin
               int r, k;
               r = $urandom_range(0, 7);
               a16 = 16'($urandom);
               if (r == 0)      b16 = a16;
               else if (r == 1) b16 = a16 ^ (16'h0001 << $urandom_range(0, 15));
               else             b16 = 16'($urandom);
               start16 = 1'b1;
               step();
               start16 = 1'b0;
               k = 0;
               while (k < 20 && !done16) begin
                  step();
                  k++;
               end
               if (!done16) chk("rnd16_timeout", 0, 1);
               step();
            end
         end
         begin
            for (int i = 0; i < 10000; i++) begin
               int k;
               a2 = 2'($urandom);
               b2 = 2'($urandom);
               start2 = 1'b1;
               step();
               start2 = 1'b0;
               k = 0;
               while (k < 10 && !done2) begin
                  step();
                  k++;
               end
               if (!done2) chk("rnd2_timeout", 0, 1);
               step();
            end
         end
      join

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
